// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/STALL sequencer in front of a synchronous instruction memory.
// Optional static backward-taken branch prediction is enabled by defining FETCH_BTFN_EN.
module rv_fetch_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_en,
    output logic [PC_W-3:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_pc4,
    output logic            if_pred_taken
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL} state_t;

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    state_t          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            imem_en_d;
    logic [PC_W-3:0] imem_addr_d;
    logic            handshake;
    logic            pred_take;
    logic            load_en;
    logic [PC_W-1:0] load_pc;
    logic [PC_W-1:0] redir_pc_al;
    logic [PC_W-1:0] pred_pc_al;

    // A redirect in flight squashes the held response, so it never handshakes.
    assign if_valid    = rsp_valid_q & ~redirect_valid;
    assign handshake   = if_valid & if_ready;
    assign redir_pc_al = redirect_pc & ALIGN_MASK;

`ifdef FETCH_BTFN_EN
    logic [PC_W-1:0] b_imm;

    assign b_imm = PC_W'({{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                          imem_rdata[30:25], imem_rdata[11:8], 1'b0});
    // Backward conditional branches (negative offset) are predicted taken.
    assign pred_take  = handshake & (imem_rdata[6:0] == 7'b1100011) & imem_rdata[31];
    assign pred_pc_al = (rsp_pc_q + b_imm) & ALIGN_MASK;
`else
    assign pred_take  = 1'b0;
    assign pred_pc_al = fetch_pc_q;
`endif

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = rsp_valid_q;
        imem_en_d   = 1'b0;
        imem_addr_d = fetch_pc_q[PC_W-1:2];
        load_en     = 1'b0;
        load_pc     = fetch_pc_q;

        if (redirect_valid) begin
            load_en = 1'b1;
            load_pc = redir_pc_al;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_BOOT: begin
                    load_en = 1'b1;
                    load_pc = RESET_PC;
                    state_d = S_RUN;
                end
                default: begin
                    if (pred_take) begin
                        load_en = 1'b1;
                        load_pc = pred_pc_al;
                        state_d = S_RUN;
                    end else if (!rsp_valid_q || handshake) begin
                        load_en = 1'b1;
                        load_pc = fetch_pc_q;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_STALL;
                    end
                end
            endcase
        end

        // Every fetch issues the read and retargets the response stage together.
        if (load_en) begin
            imem_en_d   = 1'b1;
            imem_addr_d = load_pc[PC_W-1:2];
            rsp_pc_d    = load_pc;
            rsp_valid_d = 1'b1;
            fetch_pc_d  = load_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_BOOT;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // BOOT would otherwise request a read while reset is still held.
    assign imem_en       = imem_en_d & reset;
    assign imem_addr     = imem_addr_d;
    assign if_instr      = imem_rdata;
    assign if_pc         = rsp_pc_q;
    assign if_pc4        = rsp_pc_q + PC_STEP;
    assign if_pred_taken = pred_take;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit (PC_W=8, RESET_PC=0) with a synchronous memory model.
module tb_rv_fetch_unit;

    localparam int unsigned PC_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_en;
    logic [PC_W-3:0] imem_addr;
    logic [31:0]     imem_rdata = 32'h0;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic [PC_W-1:0] if_pc4;
    logic            if_pred_taken;

    int n_cmp = 0;
    int n_err = 0;

    rv_fetch_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_pred_taken  (if_pred_taken)
    );

    always #5 clk = ~clk;

    // Word 0x0C (byte 0x30) holds beq x0,x0,-8; everything else is a tagged addi.
    function automatic logic [31:0] memf(input logic [5:0] w);
        if (w == 6'h0C) return 32'hFE000CE3;
        return {8'hA5, 2'b00, w, 16'h0013};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= memf(imem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [7:0] pc);
        check_eq({tag, "_valid"}, 32'(if_valid), 32'd1);
        check_eq({tag, "_pc"},    32'(if_pc), 32'(pc));
        check_eq({tag, "_instr"}, if_instr, memf(pc[7:2]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_imem_en",  32'(imem_en), 32'd0);
        check_eq("rst_pred",     32'(if_pred_taken), 32'd0);
        check_eq("rst_if_pc",    32'(if_pc), 32'd0);
        repeat (2) cyc();

        // Release: BOOT reads RESET_PC, no handshake this cycle.
        reset = 1'b1;
        #1;
        check_eq("boot_en",    32'(imem_en), 32'd1);
        check_eq("boot_addr",  32'(imem_addr), 32'd0);
        check_eq("boot_valid", 32'(if_valid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            check_out("seq", 8'(4 * i));
            check_eq("seq_pc4", 32'(if_pc4), 32'(8'(4 * i + 4)));
        end

        // Stall at 0x10 for three cycles.
        if_ready = 1'b0;
        #1;
        check_eq("stall_en0", 32'(imem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            check_out("stall", 8'h10);
            check_eq("stall_en", 32'(imem_en), 32'd0);
        end
        if_ready = 1'b1;
        #1;
        check_eq("resume_en",   32'(imem_en), 32'd1);
        check_eq("resume_addr", 32'(imem_addr), 32'h05);
        cyc(); #1; check_out("resume14", 8'h14);
        cyc(); #1; check_out("seq18", 8'h18);
        cyc(); #1; check_out("seq1c", 8'h1C);
        cyc(); #1; check_out("seq20", 8'h20);

        // Redirect to 0x43 while stalled at 0x20.
        if_ready = 1'b0;
        cyc(); #1; check_out("stall20", 8'h20);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h43;
        if_ready       = 1'b1;
        #1;
        check_eq("redir_mask",  32'(if_valid), 32'd0);
        check_eq("redir_en",    32'(imem_en), 32'd1);
        check_eq("redir_addr",  32'(imem_addr), 32'h10);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check_out("redir40", 8'h40);
        cyc(); #1; check_out("redir44", 8'h44);

        // Wrap-around from 0xF8.
        redirect_valid = 1'b1;
        redirect_pc    = 8'hF8;
        cyc();
        redirect_valid = 1'b0;
        #1;
        check_out("wrapf8", 8'hF8);
        cyc(); #1;
        check_out("wrapfc", 8'hFC);
        check_eq("wrap_pc4", 32'(if_pc4), 32'h00);
        cyc(); #1; check_out("wrap00", 8'h00);

        // Backward branch at 0x30.
        redirect_valid = 1'b1;
        redirect_pc    = 8'h30;
        cyc();
        redirect_valid = 1'b0;
        #1;
        check_eq("beq_valid", 32'(if_valid), 32'd1);
        check_eq("beq_pc",    32'(if_pc), 32'h30);
        check_eq("beq_instr", if_instr, 32'hFE000CE3);
`ifdef FETCH_BTFN_EN
        check_eq("beq_pred", 32'(if_pred_taken), 32'd1);
        cyc(); #1; check_out("beq_next", 8'h28);
`else
        check_eq("beq_pred", 32'(if_pred_taken), 32'd0);
        cyc(); #1; check_out("beq_next", 8'h34);
`endif
        check_eq("after_pred", 32'(if_pred_taken), 32'd0);

        // Reset asserted during a stall at 0x18.
        redirect_valid = 1'b1;
        redirect_pc    = 8'h18;
        cyc();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        #1;
        check_out("pre_rst18", 8'h18);
        cyc(); #1;
        check_out("stall18", 8'h18);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(if_valid), 32'd0);
        check_eq("mid_rst_en",    32'(imem_en), 32'd0);
        check_eq("mid_rst_pc",    32'(if_pc), 32'd0);
        cyc();
        if_ready = 1'b1;
        reset    = 1'b1;
        #1;
        check_eq("reboot_en",    32'(imem_en), 32'd1);
        check_eq("reboot_addr",  32'(imem_addr), 32'd0);
        check_eq("reboot_valid", 32'(if_valid), 32'd0);
        cyc(); #1; check_out("reboot00", 8'h00);
        cyc(); #1; check_out("reboot04", 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_fetch_unit.md
RV_FETCH_UNIT -- requirements
Module: rv_fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, giving the byte-address PC width (minimum 4).
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the first fetch byte address (word-aligned).
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port imem_en  output  1  instruction-memory read enable.
REQ-006 Port imem_addr  output  PC_W-2  word address presented to the synchronous instruction memory.
REQ-007 Port imem_rdata  input  32  instruction word, valid one cycle after an enabled read; the memory holds it while imem_en=0.
REQ-008 Port redirect_valid  input  1  branch/jump resolution requests a PC change.
REQ-009 Port redirect_pc  input  PC_W  redirect target byte address; bits [1:0] are ignored.
REQ-010 Port if_valid  output  1  the if_* outputs carry a fetched instruction.
REQ-011 Port if_ready  input  1  decode accepts the instruction this cycle.
REQ-012 Port if_instr  output  32  fetched instruction.
REQ-013 Port if_pc  output  PC_W  byte address of if_instr.
REQ-014 Port if_pc4  output  PC_W  if_pc+4, modulo 2^PC_W.
REQ-015 Port if_pred_taken  output  1  the fetch unit redirected itself after this instruction (static prediction).

Function
REQ-016 The block SHALL hold state fetch_pc (next byte address to request), rsp_pc, and rsp_valid (a response occupies the output stage).
REQ-017 The block SHALL implement FSM BOOT→RUN (one cycle after reset release); RUN→STALL when if_valid=1 and if_ready=0; STALL→RUN on if_ready=1 or redirect_valid=1.
REQ-018 In BOOT, imem_en SHALL be 1 with imem_addr=RESET_PC[PC_W-1:2]; next cycle rsp_valid=1, rsp_pc=RESET_PC, fetch_pc=RESET_PC+4.
REQ-019 if_valid SHALL equal rsp_valid AND NOT redirect_valid; if_instr=imem_rdata; if_pc=rsp_pc.
REQ-020 A handshake SHALL occur only when if_valid=1 and if_ready=1.
REQ-021 Next-address priority SHALL be: redirect_valid (redirect_pc), then prediction (REQ-032), then sequential fetch_pc.
REQ-022 On redirect_valid=1, imem_en=1, imem_addr=redirect_pc[PC_W-1:2], rsp_pc←{redirect_pc[PC_W-1:2],2'b00}, rsp_valid←1, fetch_pc←that address+4; any held response is discarded; penalty one cycle.
REQ-023 In RUN with rsp_valid=0 or a handshake, imem_en=1, imem_addr=fetch_pc word, rsp_pc←fetch_pc, rsp_valid←1, fetch_pc←fetch_pc+4.
REQ-024 In STALL (no redirect), imem_en=0 and fetch_pc, rsp_pc, and rsp_valid SHALL hold; if_instr is stable.
REQ-025 All PC arithmetic SHALL wrap modulo 2^PC_W; a fetch at 2^PC_W−4 SHALL be followed by a fetch at 0.
REQ-026 A redirect and a handshake in the same cycle SHALL produce no handshake (if_valid masked) and the redirect SHALL take effect.
REQ-027 Throughput SHALL be one instruction per cycle with if_ready held at 1 and no redirects.

Reset
REQ-028 While reset=0: if_valid=0, rsp_valid=0, rsp_pc=0, fetch_pc=RESET_PC, imem_en=0, if_pred_taken=0, and FSM=BOOT, asynchronously.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all state; after release the fetch sequence SHALL restart at RESET_PC via BOOT.
REQ-030 No handshake SHALL occur in the cycle reset is released.

Configuration
REQ-031 Macro FETCH_BTFN_EN SHALL enable static backward-taken branch prediction.
REQ-032 With FETCH_BTFN_EN defined, on a handshake where if_instr[6:0]=1100011 and if_instr[31]=1 (and no redirect), the next address SHALL be rsp_pc+B-immediate, fetched as in REQ-022, and if_pred_taken SHALL be 1 for that instruction.
REQ-033 Without FETCH_BTFN_EN, if_pred_taken SHALL be tied to 0 and fetch SHALL always be sequential unless redirected.

Verification
REQ-034 Release reset with PC_W=8, RESET_PC=0, and if_ready=1 -> if_pc sequence 0x00,0x04,0x08,... with if_valid=1 from the second cycle after release.
REQ-035 Drop if_ready to 0 for 3 cycles at if_pc=0x10 -> imem_en=0, and if_pc=0x10 and if_instr stay stable; resume delivers 0x14 next with no loss or duplication.
REQ-036 Assert redirect_valid with redirect_pc=0x43 while stalled at 0x20 -> no handshake at 0x20; the next valid if_pc=0x40, followed by 0x44.
REQ-037 Run sequentially from 0xF8 with PC_W=8 -> if_pc sequence 0xF8,0xFC,0x00.
REQ-038 With FETCH_BTFN_EN, fetch BEQ at 0x30 with immediate −8 -> if_pred_taken=1 and next if_pc=0x28; the same instruction without the macro -> next if_pc=0x34 and if_pred_taken=0.
REQ-039 Assert reset during a stall at 0x18 -> if_valid=0 immediately; after release the first valid if_pc=RESET_PC.
